// File: rtl/fwd_kin_if.sv
// Handshake bundle for fwd_kin: one angle-pair request channel and one position result channel.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high; the source
// holds valid and its payload stable until that edge, and ready may depend combinationally on state.
interface fwd_kin_if #(
  parameter int BIT_WIDTH = 32
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [BIT_WIDTH-1:0] theta1;
  logic signed [BIT_WIDTH-1:0] theta2;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [BIT_WIDTH-1:0] x;
  logic signed [BIT_WIDTH-1:0] y;

  modport master (
    output in_valid, theta1, theta2, out_ready,
    input  in_ready, out_valid, x, y
  );

  modport slave (
    input  in_valid, theta1, theta2, out_ready,
    output in_ready, out_valid, x, y
  );
endinterface

// File: rtl/fwd_kin.sv
// Two-link planar arm forward kinematics: x/y of the end effector from joint angles, using one
// shared range-reduced CORDIC rotator run once per link, Q17.15 in and out.
module fwd_kin #(
  parameter int BIT_WIDTH = 32,
  parameter int FRACTIONS = 15,
  parameter int ITER      = 16,
  parameter int L1        = 16384,
  parameter int L2        = 16384
) (
  input  logic       clock,
  input  logic       rst,
  fwd_kin_if.slave   bus,
  output logic [2:0] dbg_state
);
  localparam int W = BIT_WIDTH + 2;

  typedef logic signed [W-1:0] dp_t;
  typedef struct packed {
    dp_t x;
    dp_t y;
    dp_t z;
  } vec_t;
  typedef enum logic [2:0] {IDLE, PREP, ROT1, ROT2, SUM, DONE} state_t;

  localparam dp_t PI      = dp_t'(102944);
  localparam dp_t HALF_PI = dp_t'(51472);
  localparam dp_t TWO_PI  = dp_t'(205887);

  // CORDIC gain 0.607253 rounded to FRACTIONS bits, then folded into each link length.
  localparam longint KQ  = ((longint'(607253) << FRACTIONS) + 64'sd500000) / 64'sd1000000;
  localparam longint KL1 = (longint'(L1) * KQ) >>> FRACTIONS;
  localparam longint KL2 = (longint'(L2) * KQ) >>> FRACTIONS;
  localparam dp_t    K1  = dp_t'(KL1);
  localparam dp_t    K2  = dp_t'(KL2);

  localparam int ATAN [16] = '{25736, 15193, 8027, 4075, 2045, 1024, 512, 256,
                               128, 64, 32, 16, 8, 4, 2, 1};

  state_t state, state_n;

  logic signed [BIT_WIDTH-1:0] th1, th2;
  logic signed [BIT_WIDTH-1:0] xo, yo;
  dp_t  cx, cy, cz;
  dp_t  x2s, y2s, z2s;
  dp_t  x1r, y1r;
  logic [3:0] iter;

  // Angle preparation for both links
  dp_t  a1, a2_raw, a2;
  vec_t v1, v2;

  // Single-step rotator shared by both links
  logic d;
  logic last;
  dp_t  sx, sy, at, nx, ny, nz;

  // Pre-rotate by +/-90 degrees so the residual stays inside the CORDIC convergence range.
  function automatic vec_t reduce(input dp_t a, input dp_t kl);
    vec_t v;
    if (a > HALF_PI) begin
      v.x = '0;
      v.y = kl;
      v.z = a - HALF_PI;
    end else if (a < -HALF_PI) begin
      v.x = '0;
      v.y = -kl;
      v.z = a + HALF_PI;
    end else begin
      v.x = kl;
      v.y = '0;
      v.z = a;
    end
    return v;
  endfunction

  always_comb begin
    a1     = dp_t'(th1);
    a2_raw = a1 + dp_t'(th2);
    a2     = a2_raw;
    if (a2_raw > PI) begin
      a2 = a2_raw - TWO_PI;
    end else if (a2_raw < -PI) begin
      a2 = a2_raw + TWO_PI;
    end
    v1 = reduce(a1, K1);
    v2 = reduce(a2, K2);
  end

  always_comb begin
    d    = ~cz[W-1];
    sx   = cx >>> iter;
    sy   = cy >>> iter;
    at   = dp_t'(ATAN[iter]);
    nx   = d ? (cx - sy) : (cx + sy);
    ny   = d ? (cy + sx) : (cy - sx);
    nz   = d ? (cz - at) : (cz + at);
    last = (iter == 4'(ITER - 1));
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid) state_n = PREP;
      PREP:    state_n = ROT1;
      ROT1:    if (last) state_n = ROT2;
      ROT2:    if (last) state_n = SUM;
      SUM:     state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      th1   <= '0;
      th2   <= '0;
      cx    <= '0;
      cy    <= '0;
      cz    <= '0;
      x2s   <= '0;
      y2s   <= '0;
      z2s   <= '0;
      x1r   <= '0;
      y1r   <= '0;
      iter  <= '0;
      xo    <= '0;
      yo    <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            th1 <= bus.theta1;
            th2 <= bus.theta2;
          end
        end
        PREP: begin
          cx   <= v1.x;
          cy   <= v1.y;
          cz   <= v1.z;
          x2s  <= v2.x;
          y2s  <= v2.y;
          z2s  <= v2.z;
          iter <= '0;
        end
        ROT1: begin
          // Park link 1's result and load link 2's start vector into the shared rotator.
          if (last) begin
            x1r  <= nx;
            y1r  <= ny;
            cx   <= x2s;
            cy   <= y2s;
            cz   <= z2s;
            iter <= '0;
          end else begin
            cx   <= nx;
            cy   <= ny;
            cz   <= nz;
            iter <= iter + 4'd1;
          end
        end
        ROT2: begin
          cx   <= nx;
          cy   <= ny;
          cz   <= nz;
          iter <= last ? 4'd0 : iter + 4'd1;
        end
        SUM: begin
          xo <= BIT_WIDTH'(x1r + cx);
          yo <= BIT_WIDTH'(y1r + cy);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.x         = xo;
  assign bus.y         = yo;
  assign dbg_state     = state;
endmodule

// File: tb/tb_fwd_kin.sv
// Directed bench for fwd_kin: a trigonometric reference model feeds an expected queue that is
// checked whenever out_valid is high, alongside hand-computed poses and handshake timing checks.
module tb_fwd_kin;
  localparam int  BW  = 32;
  localparam int  TOL = 8;
  localparam int  LAT = 34;
  localparam int  PER = 36;
  localparam real LQ  = 16384.0;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic [2:0] dbg_state;
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [63:0] exp_q[$];

  fwd_kin_if #(.BIT_WIDTH(BW)) bus ();

  fwd_kin dut (
    .clock     (clock),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv, input int tol);
    int diff;
    diff = act - expv;
    if (diff < 0) diff = -diff;
    n_checks++;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, expv, tol);
    end
  endtask

  // Reference model: plain trigonometry on the real-valued angles.
  function automatic logic [63:0] model(input int t1, input int t2);
    real a1, a2;
    int  xm, ym;
    a1 = t1 / 32768.0;
    a2 = a1 + t2 / 32768.0;
    xm = int'(LQ * $cos(a1) + LQ * $cos(a2));
    ym = int'(LQ * $sin(a1) + LQ * $sin(a2));
    return {xm, ym};
  endfunction

  // Scoreboard compare on every cycle a result is presented
  always @(negedge clock) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0, 0);
      end else begin
        chk("sb_x", bus.x, exp_q[0][63:32], TOL);
        chk("sb_y", bus.y, exp_q[0][31:0], TOL);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic send(input int t1, input int t2);
    int guard;
    guard = 0;
    @(posedge clock); #1;
    bus.in_valid = 1'b1;
    bus.theta1   = t1;
    bus.theta2   = t2;
    do begin
      @(negedge clock);
      guard++;
    end while (!bus.in_ready && guard < 100);
    if (!bus.in_ready) chk("accept_timeout", 0, 1, 0);
    exp_q.push_back(model(t1, t2));
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.theta1   = $urandom;
    bus.theta2   = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 0, 1, 0);
  endtask

  task automatic release_out(input string name);
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    chk({name, "_valid_drop"}, int'(bus.out_valid), 0, 0);
    chk({name, "_in_ready_back"}, int'(bus.in_ready), 1, 0);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input string name, input int t1, input int t2,
                         input bit lit, input int ex, input int ey);
    int lat;
    send(t1, t2);
    wait_out(lat);
    chk({name, "_latency"}, lat, LAT, 0);
    if (lit) begin
      chk({name, "_x"}, bus.x, ex, TOL);
      chk({name, "_y"}, bus.y, ey, TOL);
    end
    release_out(name);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, x0, y0, accepts, rises, prev_ov;
    int rise_cyc[2];
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.theta1    = '0;
    bus.theta2    = '0;

    rst = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("reset_in_ready", int'(bus.in_ready), 0, 0);
    chk("reset_out_valid", int'(bus.out_valid), 0, 0);
    chk("reset_x", bus.x, 0, 0);
    chk("reset_y", bus.y, 0, 0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    chk("post_reset_in_ready", int'(bus.in_ready), 1, 0);

    // Hand-computed poses
    run_vec("zero",     0,       0,       1'b1,  32768,  0);
    run_vec("l1_90",    51472,   0,       1'b1,  0,      32768);
    run_vec("elbow",    0,       51472,   1'b1,  16384,  16384);
    run_vec("neg_fold", -51472,  -51472,  1'b1,  -16384, -16384);
    run_vec("wrap",     102944,  102944,  1'b1,  0,      0);
    run_vec("neg_pi",   -102944, 0,       1'b1,  -32768, 0);
    // Model-only poses across the reduction regions
    run_vec("mix_a",    -30000,  60000,   1'b0,  0, 0);
    run_vec("mix_b",    80000,   -20000,  1'b0,  0, 0);
    run_vec("mix_c",    12345,   -99999,  1'b0,  0, 0);
    run_vec("mix_d",    -70000,  90000,   1'b0,  0, 0);

    // Backpressure: result held, no new request accepted
    send(25736, 25736);
    wait_out(lat);
    chk("bp_latency", lat, LAT, 0);
    chk("bp_x", bus.x, 11585, TOL);
    chk("bp_y", bus.y, 27969, TOL);
    x0 = bus.x;
    y0 = bus.y;
    bus.in_valid = 1'b1;
    bus.theta1   = 0;
    bus.theta2   = 0;
    repeat (20) begin
      @(negedge clock);
      chk("bp_x_stable", bus.x, x0, 0);
      chk("bp_y_stable", bus.y, y0, 0);
      chk("bp_in_ready_low", int'(bus.in_ready), 0, 0);
      chk("bp_valid_held", int'(bus.out_valid), 1, 0);
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    release_out("bp");
    repeat (40) @(posedge clock);
    #1;
    chk("bp_no_extra_result", int'(bus.out_valid), 0, 0);

    // Reset in the middle of link-1 rotation
    send(51472, 0);
    repeat (10) @(posedge clock);
    #1;
    rst = 1'b1;
    @(negedge clock);
    chk("midrst_in_ready", int'(bus.in_ready), 0, 0);
    @(posedge clock); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clock);
    chk("midrst_x", bus.x, 0, 0);
    chk("midrst_y", bus.y, 0, 0);
    chk("midrst_in_ready_back", int'(bus.in_ready), 1, 0);
    repeat (40) begin
      @(negedge clock);
      chk("midrst_no_valid", int'(bus.out_valid), 0, 0);
    end
    run_vec("after_rst", 0, 0, 1'b1, 32768, 0);

    // Throughput with out_ready tied high and in_valid held
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    bus.theta1    = 0;
    bus.theta2    = 0;
    bus.in_valid  = 1'b1;
    accepts = 0;
    rises   = 0;
    prev_ov = 0;
    rise_cyc[0] = 0;
    rise_cyc[1] = 0;
    for (int k = 0; k < 300 && rises < 2; k++) begin
      @(negedge clock);
      if (bus.in_ready && bus.in_valid) begin
        accepts++;
        exp_q.push_back(model(0, 0));
      end
      if (bus.out_valid && prev_ov == 0) begin
        rise_cyc[rises] = cyc;
        rises++;
      end
      prev_ov = int'(bus.out_valid);
      @(posedge clock); #1;
      if (accepts >= 2) bus.in_valid = 1'b0;
    end
    chk("tp_results", rises, 2, 0);
    chk("tp_period", rise_cyc[1] - rise_cyc[0], PER, 0);
    repeat (5) @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    chk("drain_queue_empty", exp_q.size(), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
